// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - PC, instruction-memory and decode-side signals of the fetch stage
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            pc_valid_i;
    logic [XLEN-1:0] pc_i;
    logic            pc_ready_o;
    logic            redirect_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    modport master (
        input  pc_valid_i, pc_i, redirect_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output pc_valid_i, pc_i, redirect_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - credit-limited in-order instruction fetch with redirect squash
module instr_fetch #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = CW + 2;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] req_pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   pcq_wr_q;
    logic [CW-1:0]   pcq_rd_q;
    logic [XLEN-1:0] pcq_mem [DEPTH];
    logic [CW-1:0]   fifo_wr_q;
    logic [CW-1:0]   fifo_rd_q;
    logic [CW-1:0]   fifo_count_q;
    logic [XLEN-1:0] fifo_pc [DEPTH];
    logic [31:0]     fifo_data [DEPTH];

    logic [UW-1:0] used;
    logic          req_pending;
    logic          credit_ok;
    logic          granted;
    logic          pc_ready;
    logic          accept;
    logic          rsp;
    logic          rsp_keep;
    logic          fifo_pop;

    // A pending request already owns a slot, so every granted word is guaranteed FIFO space.
    assign req_pending = (state_q == REQ);
    assign used        = UW'(fifo_count_q) + UW'(outstanding_q) + UW'(req_pending);
    assign credit_ok   = (used < UW'(DEPTH));
    assign granted     = req_pending && bus.imem_gnt_i;
    assign accept      = bus.pc_valid_i && pc_ready;
    // Responses with nothing outstanding belong to requests abandoned by reset.
    assign rsp         = bus.imem_rvalid_i && (outstanding_q != '0);
    assign rsp_keep    = rsp && (discard_q == '0) && !bus.redirect_i;
    assign fifo_pop    = (fifo_count_q != '0) && bus.instr_ready_i && !bus.redirect_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (granted) state_d = accept ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In REQ a new PC can only be taken in the cycle the current one is granted.
    always_comb begin
        pc_ready       = 1'b0;
        if (rst_n && credit_ok && !bus.redirect_i) begin
            pc_ready = (state_q == IDLE) || granted;
        end
        bus.pc_ready_o = pc_ready;
        bus.imem_req_o = req_pending;
    end

    assign bus.imem_addr_o   = addr_q;
    assign bus.instr_valid_o = (fifo_count_q != '0);
    assign bus.instr_o       = fifo_data[fifo_rd_q[AW-1:0]];
    assign bus.instr_pc_o    = fifo_pc[fifo_rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q        <= '0;
            req_pc_q      <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcq_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                addr_q   <= {bus.pc_i[XLEN-1:2], 2'b00};
                req_pc_q <= bus.pc_i;
            end
            if (granted) begin
                pcq_mem[pcq_wr_q[AW-1:0]] <= req_pc_q;
                pcq_wr_q                  <= pcq_wr_q + CW'(1);
            end
            if (rsp) begin
                pcq_rd_q <= pcq_rd_q + CW'(1);
            end
            outstanding_q <= outstanding_q + CW'(granted) - CW'(rsp);
            // Everything issued before a redirect is stale, including a request not yet granted.
            if (bus.redirect_i) begin
                discard_q <= outstanding_q + CW'(req_pending) - CW'(rsp);
            end else if (rsp && (discard_q != '0)) begin
                discard_q <= discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (bus.redirect_i) begin
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_count_q <= '0;
        end else begin
            if (rsp_keep) begin
                fifo_pc[fifo_wr_q[AW-1:0]]   <= pcq_mem[pcq_rd_q[AW-1:0]];
                fifo_data[fifo_wr_q[AW-1:0]] <= bus.imem_rdata_i;
                fifo_wr_q                    <= fifo_wr_q + CW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_q <= fifo_rd_q + CW'(1);
            end
            fifo_count_q <= fifo_count_q + CW'(rsp_keep) - CW'(fifo_pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed bench for instr_fetch against a queue model
module tb_instr_fetch;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.XLEN(XLEN)) bus ();

    instr_fetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        bit          squash;
    } fly_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } out_t;

    // Model: accepted-not-granted, granted-not-returned, and returned-not-consumed fetches.
    fly_t pend_q[$];
    fly_t fly_q[$];
    out_t out_q[$];
    fly_t f;

    int vectors     = 0;
    int miscompares = 0;
    int gnt_pct     = 100;
    int rsp_pct     = 100;
    bit stray       = 1'b0;
    int n_out       = 0;
    int inflight;
    bit prev_stall;
    logic [31:0] prev_addr;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory responder plus scoreboard: observe at negedge, drive just after posedge.
    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        prev_stall        = 1'b0;
        prev_addr         = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_q.delete();
                fly_q.delete();
                out_q.delete();
                prev_stall = 1'b0;
            end else begin
                vectors++;
                if (bus.instr_valid_o !== (out_q.size() != 0)) begin
                    miscompares++;
                    $display("FAIL instr_valid: got %b want %b", bus.instr_valid_o, out_q.size() != 0);
                end
                if (bus.instr_valid_o === 1'b1 && out_q.size() != 0) begin
                    vectors++;
                    if ({bus.instr_pc_o, bus.instr_o} !== {out_q[0].pc, out_q[0].data}) begin
                        miscompares++;
                        $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h",
                                 bus.instr_pc_o, bus.instr_o, out_q[0].pc, out_q[0].data);
                    end
                end
                if (prev_stall && bus.imem_req_o === 1'b1) begin
                    vectors++;
                    if (bus.imem_addr_o !== prev_addr) begin
                        miscompares++;
                        $display("FAIL addr_stable: got %h want %h", bus.imem_addr_o, prev_addr);
                    end
                end
                inflight = pend_q.size() + fly_q.size() + out_q.size();
                vectors++;
                if (inflight > DEPTH) begin
                    miscompares++;
                    $display("FAIL credit: got %0d in flight want <= %0d", inflight, DEPTH);
                end
                if (bus.redirect_i) begin
                    vectors++;
                    if (bus.pc_ready_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL ready_in_redirect: got %b want 0", bus.pc_ready_o);
                    end
                end
                if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i && !bus.redirect_i && out_q.size() != 0) begin
                    void'(out_q.pop_front());
                    n_out++;
                end
                if (bus.imem_rvalid_i && fly_q.size() != 0) begin
                    f = fly_q.pop_front();
                    if (!f.squash && !bus.redirect_i)
                        out_q.push_back('{pc: f.pc, data: mem_word(align(f.pc))});
                end
                if (bus.imem_req_o === 1'b1 && bus.imem_gnt_i) begin
                    vectors++;
                    if (pend_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL grant: got request %h want none pending", bus.imem_addr_o);
                    end else begin
                        if (bus.imem_addr_o !== align(pend_q[0].pc)) begin
                            miscompares++;
                            $display("FAIL imem_addr: got %h want %h", bus.imem_addr_o, align(pend_q[0].pc));
                        end
                        fly_q.push_back(pend_q.pop_front());
                    end
                end
                if (bus.redirect_i) begin
                    foreach (pend_q[k]) pend_q[k].squash = 1'b1;
                    foreach (fly_q[k]) fly_q[k].squash = 1'b1;
                    out_q.delete();
                end
                if (bus.pc_valid_i && bus.pc_ready_o === 1'b1)
                    pend_q.push_back('{pc: bus.pc_i, squash: 1'b0});
                prev_stall = (bus.imem_req_o === 1'b1) && !bus.imem_gnt_i;
                prev_addr  = bus.imem_addr_o;
            end
            @(posedge clk);
            #1;
            bus.imem_gnt_i = rst_n && ($urandom_range(0, 99) < gnt_pct);
            if (rst_n && fly_q.size() != 0 && $urandom_range(0, 99) < rsp_pct) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(align(fly_q[0].pc));
            end else begin
                bus.imem_rvalid_i = stray;
                bus.imem_rdata_i  = $urandom;
            end
        end
    end

    task automatic send_pc(input logic [31:0] pc);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = pc;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (bus.pc_ready_o === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.pc_valid_i = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_pc %h: got ready=0 want accepted", pc);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus.instr_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.pc_ready_o} !== '0) begin
            miscompares++;
            $display("FAIL reset: got req=%b addr=%h valid=%b instr=%h pc=%h ready=%b want all 0",
                     bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.pc_ready_o);
        end
        @(posedge clk);
        #1;
        bus.pc_valid_i = 1'b0;
        rst_n          = 1'b1;
    endtask

    task automatic test_single_fetch;
        @(negedge clk);
        gnt_pct = 100;
        rsp_pct = 100;
        bus.instr_ready_i = 1'b1;
        send_pc(32'h100);
        @(negedge clk);
        vectors++;
        if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL single_req: got req=%b addr=%h want 1/00000100", bus.imem_req_o, bus.imem_addr_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: got valid=%b want 0", bus.instr_valid_o);
        end
        @(negedge clk);
        vectors++;
        if ({bus.instr_valid_o, bus.instr_o, bus.instr_pc_o} !== {1'b1, 32'h13, 32'h100}) begin
            miscompares++;
            $display("FAIL single_out: got valid=%b instr=%h pc=%h want 1/00000013/00000100",
                     bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_misaligned;
        bit ok;
        send_pc(32'h103);
        @(negedge clk);
        vectors++;
        if (bus.imem_addr_o !== 32'h100) begin
            miscompares++;
            $display("FAIL misaligned_addr: got %h want 00000100", bus.imem_addr_o);
        end
        wait_valid(20, ok);
        vectors++;
        if (!ok || bus.instr_pc_o !== 32'h103 || bus.instr_o !== 32'h13) begin
            miscompares++;
            $display("FAIL misaligned_out: got ok=%b pc=%h instr=%h want 1/00000103/00000013", ok, bus.instr_pc_o, bus.instr_o);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_grant_stall;
        int n0;
        @(negedge clk);
        gnt_pct = 0;
        n0 = n_out;
        send_pc(32'h20);
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h20}) begin
                miscompares++;
                $display("FAIL stall_hold: got req=%b addr=%h want 1/00000020", bus.imem_req_o, bus.imem_addr_o);
            end
        end
        gnt_pct = 100;
        repeat (10) @(negedge clk);
        vectors++;
        if (n_out - n0 != 1) begin
            miscompares++;
            $display("FAIL stall_count: got %0d outputs want 1", n_out - n0);
        end
    endtask

    task automatic test_streaming;
        int i   = 0;
        int cyc = 0;
        int n0  = n_out;
        while (i < 4 && cyc < 100) begin
            @(posedge clk);
            #1;
            bus.pc_valid_i = 1'b1;
            bus.pc_i       = 32'(i * 4);
            @(negedge clk);
            if (bus.pc_ready_o === 1'b1) i++;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.pc_valid_i = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (i != 4 || n_out - n0 != 4) begin
            miscompares++;
            $display("FAIL streaming: got %0d accepted %0d outputs want 4/4", i, n_out - n0);
        end
    endtask

    task automatic test_backpressure;
        int  n0;
        bit  done = 1'b0;
        @(negedge clk);
        bus.instr_ready_i = 1'b0;
        n0 = n_out;
        send_pc(32'h0);
        send_pc(32'h4);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h8;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({bus.pc_ready_o, bus.instr_valid_o, bus.instr_pc_o} !== {1'b0, 1'b1, 32'h0}) begin
                miscompares++;
                $display("FAIL backpressure_hold: got ready=%b valid=%b pc=%h want 0/1/00000000",
                         bus.pc_ready_o, bus.instr_valid_o, bus.instr_pc_o);
            end
        end
        bus.instr_ready_i = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.pc_ready_o === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.pc_valid_i = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (!done || n_out - n0 != 3) begin
            miscompares++;
            $display("FAIL backpressure_resume: got resumed=%b outputs=%0d want 1/3", done, n_out - n0);
        end
    endtask

    task automatic test_redirect;
        bit ok;
        @(negedge clk);
        bus.instr_ready_i = 1'b0;
        gnt_pct = 100;
        rsp_pct = 100;
        send_pc(32'h40);
        repeat (4) @(negedge clk);
        rsp_pct = 0;
        send_pc(32'h44);
        @(posedge clk);
        #1;
        bus.redirect_i = 1'b1;
        @(posedge clk);
        #1;
        bus.redirect_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_flush: got valid=%b want 0", bus.instr_valid_o);
        end
        rsp_pct = 100;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_stale: got valid=%b want 0", bus.instr_valid_o);
        end
        bus.instr_ready_i = 1'b1;
        send_pc(32'h200);
        wait_valid(20, ok);
        vectors++;
        if (!ok || bus.instr_pc_o !== 32'h200 || bus.instr_o !== mem_word(32'h200)) begin
            miscompares++;
            $display("FAIL redirect_new: got ok=%b pc=%h instr=%h want 1/00000200/%h",
                     ok, bus.instr_pc_o, bus.instr_o, mem_word(32'h200));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_req;
        bit ok;
        @(negedge clk);
        gnt_pct = 0;
        send_pc(32'h300);
        @(negedge clk);
        vectors++;
        if (bus.imem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_req: got req=%b want 1", bus.imem_req_o);
        end
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.pc_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.pc_ready_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_req: got req=%b addr=%h valid=%b instr=%h pc=%h ready=%b want all 0",
                     bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, bus.pc_ready_o);
        end
        @(posedge clk);
        #1;
        bus.pc_valid_i = 1'b0;
        rst_n          = 1'b1;
        gnt_pct        = 100;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_rvalid: got valid=%b want 0", bus.instr_valid_o);
        end
        send_pc(32'h304);
        wait_valid(20, ok);
        vectors++;
        if (!ok || bus.instr_pc_o !== 32'h304) begin
            miscompares++;
            $display("FAIL post_reset_fetch: got ok=%b pc=%h want 1/00000304", ok, bus.instr_pc_o);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c % 200 == 0) begin
                gnt_pct = $urandom_range(20, 100);
                rsp_pct = $urandom_range(20, 100);
            end
            bus.pc_valid_i    = ($urandom_range(0, 99) < 60);
            bus.pc_i          = $urandom;
            bus.instr_ready_i = ($urandom_range(0, 99) < 70);
            bus.redirect_i    = ($urandom_range(0, 99) < 3);
        end
        @(posedge clk);
        #1;
        bus.pc_valid_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.instr_ready_i = 1'b1;
        gnt_pct           = 100;
        rsp_pct           = 100;
        repeat (20) @(negedge clk);
        vectors++;
        if ({bus.instr_valid_o, bus.imem_req_o} !== 2'b00 || out_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain: got valid=%b req=%b left=%0d want 0/0/0",
                     bus.instr_valid_o, bus.imem_req_o, out_q.size());
        end
    endtask

    initial begin
        bus.pc_valid_i    = 1'b0;
        bus.pc_i          = '0;
        bus.redirect_i    = 1'b0;
        bus.instr_ready_i = 1'b1;
        test_reset;
        test_single_fetch;
        test_misaligned;
        test_grant_stall;
        test_streaming;
        test_backpressure;
        test_redirect;
        test_reset_mid_req;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
